// File: rtl/axi_defines_pkg.sv
// AXI4 constants shared by the bus initiator, plus its FSM state encoding.
package axi_defines;

    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam int unsigned ID_WIDTH = 4;
    localparam logic [ID_WIDTH-1:0] DEFAULT_ID = '0;

    typedef enum logic [2:0] {
        StIdle = 3'd0,
        StAr   = 3'd1,
        StR    = 3'd2,
        StAw   = 3'd3,
        StW    = 3'd4,
        StB    = 3'd5,
        StResp = 3'd6
    } axi_state_e;

endpackage

// File: rtl/ysyx_22050710_axi4full_master_reg.sv
// Generic load-enabled register with synchronous active-high reset.
module ysyx_22050710_axi4full_master_reg #(
    parameter int unsigned        WIDTH     = 1,
    parameter logic [WIDTH-1:0]   RESET_VAL = '0
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_wen,
    input  logic [WIDTH-1:0] i_din,
    output logic [WIDTH-1:0] o_dout
);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_dout <= RESET_VAL;
        end else if (i_wen) begin
            o_dout <= i_din;
        end
    end

endmodule

// File: rtl/ysyx_22050710_axi4full_master.sv
// AXI4-full initiator: one outstanding single-beat or INCR-burst read or write,
// bridged from a simple request / beat-stream / completion interface.
module ysyx_22050710_axi4full_master
    import axi_defines::*;
#(
    parameter int unsigned          DATA_WIDTH = 64,
    parameter int unsigned          ADDR_WIDTH = 32,
    parameter int unsigned          STRB_WIDTH = DATA_WIDTH / 8,
    parameter logic [ID_WIDTH-1:0]  AXI_ID     = DEFAULT_ID
) (
    input  logic                  i_aclk,
    input  logic                  i_rst,

    input  logic                  i_req_valid,
    output logic                  o_req_ready,
    input  logic                  i_req_wen,
    input  logic [ADDR_WIDTH-1:0] i_req_addr,
    input  logic [7:0]            i_req_len,
    input  logic [2:0]            i_req_size,

    input  logic                  i_wd_valid,
    output logic                  o_wd_ready,
    input  logic [DATA_WIDTH-1:0] i_wd_data,
    input  logic [STRB_WIDTH-1:0] i_wd_strb,

    output logic                  o_rd_valid,
    input  logic                  i_rd_ready,
    output logic [DATA_WIDTH-1:0] o_rd_data,
    output logic                  o_rd_last,

    output logic                  o_resp_valid,
    input  logic                  i_resp_ready,
    output logic                  o_resp_err,

    output logic [ID_WIDTH-1:0]   o_awid,
    output logic [ADDR_WIDTH-1:0] o_awaddr,
    output logic [7:0]            o_awlen,
    output logic [2:0]            o_awsize,
    output logic [1:0]            o_awburst,
    output logic                  o_awlock,
    output logic [3:0]            o_awcache,
    output logic [2:0]            o_awprot,
    output logic                  o_awvalid,
    input  logic                  i_awready,

    output logic [ID_WIDTH-1:0]   o_wid,
    output logic [DATA_WIDTH-1:0] o_wdata,
    output logic [STRB_WIDTH-1:0] o_wstrb,
    output logic                  o_wlast,
    output logic                  o_wvalid,
    input  logic                  i_wready,

    input  logic [ID_WIDTH-1:0]   i_bid,
    input  logic [1:0]            i_bresp,
    input  logic                  i_bvalid,
    output logic                  o_bready,

    output logic [ID_WIDTH-1:0]   o_arid,
    output logic [ADDR_WIDTH-1:0] o_araddr,
    output logic [7:0]            o_arlen,
    output logic [2:0]            o_arsize,
    output logic [1:0]            o_arburst,
    output logic                  o_arlock,
    output logic [3:0]            o_arcache,
    output logic [2:0]            o_arprot,
    output logic                  o_arvalid,
    input  logic                  i_arready,

    input  logic [ID_WIDTH-1:0]   i_rid,
    input  logic [DATA_WIDTH-1:0] i_rdata,
    input  logic [1:0]            i_rresp,
    input  logic                  i_rlast,
    input  logic                  i_rvalid,
    output logic                  o_rready
);

    axi_state_e r_state;
    logic r_req_ready, r_arvalid, r_awvalid, r_bready, r_resp_valid;
    logic r_in_r, r_in_w;

    logic [ADDR_WIDTH-1:0] r_addr;
    logic [7:0]            r_len;
    logic [2:0]            r_size;
    logic [7:0]            r_cnt;
    logic                  r_err;

    logic       w_req_fire, w_ar_fire, w_aw_fire, w_r_fire, w_w_fire, w_b_fire, w_resp_fire;
    logic       w_wlast, w_beat_room, w_rbeat_bad, w_bresp_bad;
    logic       w_cnt_wen;
    logic [7:0] w_cnt_d;
    logic       w_err_d;

    assign w_req_fire  = i_req_valid & r_req_ready;
    assign w_ar_fire   = r_arvalid & i_arready;
    assign w_aw_fire   = r_awvalid & i_awready;
    assign w_r_fire    = r_in_r & i_rvalid & i_rd_ready;
    assign w_w_fire    = r_in_w & i_wd_valid & i_wready;
    assign w_b_fire    = r_bready & i_bvalid;
    assign w_resp_fire = r_resp_valid & i_resp_ready;

    assign w_wlast = (r_cnt == r_len);

    // Counter stops at len+1 so an overrunning read burst cannot wrap it.
    assign w_beat_room = (r_cnt <= r_len) && (r_cnt != 8'hFF);

    assign w_rbeat_bad = (i_rresp != RESP_OKAY) || (i_rid != AXI_ID) ||
                         (i_rlast && (r_cnt != r_len)) ||
                         (!i_rlast && (r_cnt >= r_len));
    assign w_bresp_bad = (i_bresp != RESP_OKAY) || (i_bid != AXI_ID);

    always_comb begin
        w_cnt_wen = 1'b0;
        w_cnt_d   = r_cnt;
        if (w_req_fire) begin
            w_cnt_wen = 1'b1;
            w_cnt_d   = 8'd0;
        end else if ((w_r_fire || w_w_fire) && w_beat_room) begin
            w_cnt_wen = 1'b1;
            w_cnt_d   = r_cnt + 8'd1;
        end
    end

    always_comb begin
        w_err_d = r_err;
        if (w_req_fire) begin
            w_err_d = 1'b0;
        end else if ((w_r_fire && w_rbeat_bad) || (w_b_fire && w_bresp_bad)) begin
            w_err_d = 1'b1;
        end
    end

    ysyx_22050710_axi4full_master_reg #(.WIDTH(ADDR_WIDTH), .RESET_VAL('0)) u_addr_reg (
        .i_clk(i_aclk), .i_rst(i_rst), .i_wen(w_req_fire), .i_din(i_req_addr), .o_dout(r_addr)
    );

    ysyx_22050710_axi4full_master_reg #(.WIDTH(8), .RESET_VAL('0)) u_len_reg (
        .i_clk(i_aclk), .i_rst(i_rst), .i_wen(w_req_fire), .i_din(i_req_len), .o_dout(r_len)
    );

    ysyx_22050710_axi4full_master_reg #(.WIDTH(3), .RESET_VAL('0)) u_size_reg (
        .i_clk(i_aclk), .i_rst(i_rst), .i_wen(w_req_fire), .i_din(i_req_size), .o_dout(r_size)
    );

    ysyx_22050710_axi4full_master_reg #(.WIDTH(8), .RESET_VAL('0)) u_cnt_reg (
        .i_clk(i_aclk), .i_rst(i_rst), .i_wen(w_cnt_wen), .i_din(w_cnt_d), .o_dout(r_cnt)
    );

    ysyx_22050710_axi4full_master_reg #(.WIDTH(1), .RESET_VAL(1'b0)) u_err_reg (
        .i_clk(i_aclk), .i_rst(i_rst), .i_wen(1'b1), .i_din(w_err_d), .o_dout(r_err)
    );

    // Handshake outputs are registered alongside the state so each valid rises
    // on the cycle the state is entered and is stable until its ready.
    always_ff @(posedge i_aclk) begin
        if (i_rst) begin
            r_state      <= StIdle;
            r_req_ready  <= 1'b1;
            r_arvalid    <= 1'b0;
            r_awvalid    <= 1'b0;
            r_bready     <= 1'b0;
            r_resp_valid <= 1'b0;
            r_in_r       <= 1'b0;
            r_in_w       <= 1'b0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (w_req_fire) begin
                        r_req_ready <= 1'b0;
                        if (i_req_wen) begin
                            r_state   <= StAw;
                            r_awvalid <= 1'b1;
                        end else begin
                            r_state   <= StAr;
                            r_arvalid <= 1'b1;
                        end
                    end
                end
                StAr: begin
                    if (w_ar_fire) begin
                        r_state   <= StR;
                        r_arvalid <= 1'b0;
                        r_in_r    <= 1'b1;
                    end
                end
                StR: begin
                    if (w_r_fire && i_rlast) begin
                        r_state      <= StResp;
                        r_in_r       <= 1'b0;
                        r_resp_valid <= 1'b1;
                    end
                end
                StAw: begin
                    if (w_aw_fire) begin
                        r_state   <= StW;
                        r_awvalid <= 1'b0;
                        r_in_w    <= 1'b1;
                    end
                end
                StW: begin
                    if (w_w_fire && w_wlast) begin
                        r_state  <= StB;
                        r_in_w   <= 1'b0;
                        r_bready <= 1'b1;
                    end
                end
                StB: begin
                    if (w_b_fire) begin
                        r_state      <= StResp;
                        r_bready     <= 1'b0;
                        r_resp_valid <= 1'b1;
                    end
                end
                StResp: begin
                    if (w_resp_fire) begin
                        r_state      <= StIdle;
                        r_resp_valid <= 1'b0;
                        r_req_ready  <= 1'b1;
                    end
                end
                default: begin
                    r_state      <= StIdle;
                    r_req_ready  <= 1'b1;
                    r_arvalid    <= 1'b0;
                    r_awvalid    <= 1'b0;
                    r_bready     <= 1'b0;
                    r_resp_valid <= 1'b0;
                    r_in_r       <= 1'b0;
                    r_in_w       <= 1'b0;
                end
            endcase
        end
    end

    assign o_req_ready  = r_req_ready;
    assign o_resp_valid = r_resp_valid;
    assign o_resp_err   = r_err;

    assign o_arid    = AXI_ID;
    assign o_araddr  = r_addr;
    assign o_arlen   = r_len;
    assign o_arsize  = r_size;
    assign o_arburst = BURST_INCR;
    assign o_arlock  = 1'b0;
    assign o_arcache = 4'd0;
    assign o_arprot  = 3'd0;
    assign o_arvalid = r_arvalid;

    assign o_awid    = AXI_ID;
    assign o_awaddr  = r_addr;
    assign o_awlen   = r_len;
    assign o_awsize  = r_size;
    assign o_awburst = BURST_INCR;
    assign o_awlock  = 1'b0;
    assign o_awcache = 4'd0;
    assign o_awprot  = 3'd0;
    assign o_awvalid = r_awvalid;

    assign o_wid      = AXI_ID;
    assign o_wdata    = i_wd_data;
    assign o_wstrb    = i_wd_strb;
    assign o_wlast    = r_in_w & w_wlast;
    assign o_wvalid   = r_in_w & i_wd_valid;
    assign o_wd_ready = r_in_w & i_wready;

    assign o_bready = r_bready;

    assign o_rready   = r_in_r & i_rd_ready;
    assign o_rd_valid = r_in_r & i_rvalid;
    assign o_rd_data  = i_rdata;
    assign o_rd_last  = r_in_r & i_rlast;

endmodule

// File: tb/tb_ysyx_22050710_axi4full_master.sv
// Randomized bench: an in-bench AXI slave and client drive the initiator and
// check every beat and completion against transaction-level expectations.
module tb_ysyx_22050710_axi4full_master;

    logic        i_aclk = 1'b0;
    logic        i_rst;
    logic        i_req_valid, o_req_ready, i_req_wen;
    logic [31:0] i_req_addr;
    logic [7:0]  i_req_len;
    logic [2:0]  i_req_size;
    logic        i_wd_valid, o_wd_ready;
    logic [63:0] i_wd_data;
    logic [7:0]  i_wd_strb;
    logic        o_rd_valid, i_rd_ready, o_rd_last;
    logic [63:0] o_rd_data;
    logic        o_resp_valid, i_resp_ready, o_resp_err;
    logic [3:0]  o_awid, o_awcache, o_arid, o_arcache, o_wid, i_bid, i_rid;
    logic [31:0] o_awaddr, o_araddr;
    logic [7:0]  o_awlen, o_arlen, o_wstrb;
    logic [2:0]  o_awsize, o_awprot, o_arsize, o_arprot;
    logic [1:0]  o_awburst, o_arburst, i_bresp, i_rresp;
    logic        o_awlock, o_awvalid, i_awready, o_arlock, o_arvalid, i_arready;
    logic [63:0] o_wdata, i_rdata;
    logic        o_wlast, o_wvalid, i_wready, i_bvalid, o_bready;
    logic        i_rlast, i_rvalid, o_rready;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    logic [63:0] slv_rdata[$];
    logic [63:0] wr_data[$];
    logic [7:0]  wr_strb[$];

    ysyx_22050710_axi4full_master dut (
        .i_aclk(i_aclk), .i_rst(i_rst),
        .i_req_valid(i_req_valid), .o_req_ready(o_req_ready), .i_req_wen(i_req_wen),
        .i_req_addr(i_req_addr), .i_req_len(i_req_len), .i_req_size(i_req_size),
        .i_wd_valid(i_wd_valid), .o_wd_ready(o_wd_ready), .i_wd_data(i_wd_data),
        .i_wd_strb(i_wd_strb),
        .o_rd_valid(o_rd_valid), .i_rd_ready(i_rd_ready), .o_rd_data(o_rd_data),
        .o_rd_last(o_rd_last),
        .o_resp_valid(o_resp_valid), .i_resp_ready(i_resp_ready), .o_resp_err(o_resp_err),
        .o_awid(o_awid), .o_awaddr(o_awaddr), .o_awlen(o_awlen), .o_awsize(o_awsize),
        .o_awburst(o_awburst), .o_awlock(o_awlock), .o_awcache(o_awcache),
        .o_awprot(o_awprot), .o_awvalid(o_awvalid), .i_awready(i_awready),
        .o_wid(o_wid), .o_wdata(o_wdata), .o_wstrb(o_wstrb), .o_wlast(o_wlast),
        .o_wvalid(o_wvalid), .i_wready(i_wready),
        .i_bid(i_bid), .i_bresp(i_bresp), .i_bvalid(i_bvalid), .o_bready(o_bready),
        .o_arid(o_arid), .o_araddr(o_araddr), .o_arlen(o_arlen), .o_arsize(o_arsize),
        .o_arburst(o_arburst), .o_arlock(o_arlock), .o_arcache(o_arcache),
        .o_arprot(o_arprot), .o_arvalid(o_arvalid), .i_arready(i_arready),
        .i_rid(i_rid), .i_rdata(i_rdata), .i_rresp(i_rresp), .i_rlast(i_rlast),
        .i_rvalid(i_rvalid), .o_rready(o_rready)
    );

    always #5 i_aclk = ~i_aclk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        i_req_valid = 1'b0; i_req_wen = 1'b0; i_req_addr = '0; i_req_len = '0; i_req_size = '0;
        i_wd_valid = 1'b0; i_wd_data = '0; i_wd_strb = '0; i_rd_ready = 1'b0;
        i_resp_ready = 1'b0; i_awready = 1'b0; i_wready = 1'b0;
        i_bid = '0; i_bresp = '0; i_bvalid = 1'b0; i_arready = 1'b0;
        i_rid = '0; i_rdata = '0; i_rresp = '0; i_rlast = 1'b0; i_rvalid = 1'b0;
    endtask

    // rdy_mode: 0 = always ready, 1 = toggles every cycle, 2 = random
    task automatic do_read(input logic [31:0] addr, input logic [7:0] len, input int nbeats,
                           input int err_beat, input int rdy_mode, input bit slv_rand,
                           input int exp_lat);
        int cyc = 0;
        int beat = 0;
        bit ar_done = 1'b0, rv = 1'b0, resp_seen = 1'b0, done = 1'b0, exp_err;
        exp_err = (nbeats != int'(len) + 1) || (err_beat >= 0 && err_beat < nbeats);
        @(negedge i_aclk);
        idle_inputs();
        i_req_valid = 1'b1; i_req_wen = 1'b0; i_req_addr = addr;
        i_req_len = len; i_req_size = 3'd3;
        #1 check_eq("rd_req_ready", o_req_ready, 1'b1);
        while (!done && cyc < 400) begin
            @(negedge i_aclk);
            cyc++;
            i_req_valid = 1'b0;
            i_arready = slv_rand ? 1'($urandom_range(0, 1)) : 1'b1;
            if (!rv && ar_done && beat < nbeats)
                rv = slv_rand ? ($urandom_range(0, 2) != 0) : 1'b1;
            i_rvalid = rv;
            i_rdata  = (beat < nbeats) ? slv_rdata[beat] : 64'd0;
            i_rlast  = (beat == nbeats - 1);
            i_rresp  = (beat == err_beat) ? 2'b10 : 2'b00;
            i_rid    = '0;
            case (rdy_mode)
                0:       i_rd_ready = 1'b1;
                1:       i_rd_ready = (cyc % 2 == 0);
                default: i_rd_ready = 1'($urandom_range(0, 1));
            endcase
            i_resp_ready = slv_rand ? 1'($urandom_range(0, 1)) : 1'b1;
            #1;
            check_eq("rd_req_ready_busy", o_req_ready, 1'b0);
            if (!ar_done) begin
                check_eq("arvalid_hold", o_arvalid, 1'b1);
                if (cyc == 1) begin
                    check_eq("araddr", o_araddr, addr);
                    check_eq("arlen", o_arlen, len);
                    check_eq("arsize", o_arsize, 3'd3);
                    check_eq("arburst", o_arburst, 2'b01);
                    check_eq("arid", o_arid, 4'd0);
                    check_eq("ar_fixed", {o_arlock, o_arcache, o_arprot}, 8'd0);
                end
                if (o_arvalid && i_arready) ar_done = 1'b1;
            end
            if (rv) begin
                check_eq("rd_valid_pass", o_rd_valid, 1'b1);
                check_eq("rready_pass", o_rready, i_rd_ready);
                if (o_rready) begin
                    check_eq("rd_data", o_rd_data, slv_rdata[beat]);
                    check_eq("rd_last", o_rd_last, beat == nbeats - 1);
                    beat++;
                    rv = 1'b0;
                end
            end
            if (o_resp_valid) begin
                if (!resp_seen) begin
                    resp_seen = 1'b1;
                    check_eq("rd_err", o_resp_err, exp_err);
                    check_eq("rd_beats", beat, nbeats);
                    if (exp_lat >= 0) check_eq("rd_latency", cyc, exp_lat);
                end
                if (i_resp_ready) done = 1'b1;
            end
        end
        check_eq("rd_done", done, 1'b1);
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [7:0] len, input int wd_delay,
                            input logic [1:0] bresp, input logic [3:0] bid, input bit slv_rand,
                            input bit early, input int exp_lat, input int abort_after);
        int cyc = 0;
        int wbeat = 0;
        int since_aw = 0;
        bit aw_done = 1'b0, w_done = 1'b0, b_done = 1'b0, wv = 1'b0, bv = 1'b0;
        bit resp_seen = 1'b0, done = 1'b0, aborted = 1'b0, allow, exp_err;
        exp_err = (bresp != 2'b00) || (bid != 4'd0);
        @(negedge i_aclk);
        idle_inputs();
        i_req_valid = 1'b1; i_req_wen = 1'b1; i_req_addr = addr;
        i_req_len = len; i_req_size = 3'd3;
        #1 check_eq("wr_req_ready", o_req_ready, 1'b1);
        while (!done && !aborted && cyc < 400) begin
            @(negedge i_aclk);
            cyc++;
            i_req_valid = 1'b0;
            if (aw_done) since_aw++;
            i_awready = slv_rand ? 1'($urandom_range(0, 1)) : 1'b1;
            allow = !w_done && (aw_done ? (since_aw > wd_delay) : early);
            if (!wv && allow) wv = slv_rand ? 1'($urandom_range(0, 1)) : 1'b1;
            i_wd_valid = wv;
            i_wd_data  = (wbeat <= int'(len)) ? wr_data[wbeat] : 64'd0;
            i_wd_strb  = (wbeat <= int'(len)) ? wr_strb[wbeat] : 8'd0;
            i_wready   = slv_rand ? 1'($urandom_range(0, 1)) : 1'b1;
            if (!bv && w_done && !b_done) bv = slv_rand ? 1'($urandom_range(0, 1)) : 1'b1;
            i_bvalid = bv; i_bresp = bresp; i_bid = bid;
            i_resp_ready = slv_rand ? 1'($urandom_range(0, 1)) : 1'b1;
            #1;
            check_eq("wr_req_ready_busy", o_req_ready, 1'b0);
            if (!aw_done) begin
                check_eq("awvalid_hold", o_awvalid, 1'b1);
                check_eq("w_before_aw", o_wvalid, 1'b0);
                check_eq("wd_ready_before_aw", o_wd_ready, 1'b0);
                if (cyc == 1) begin
                    check_eq("awaddr", o_awaddr, addr);
                    check_eq("awlen", o_awlen, len);
                    check_eq("awsize", o_awsize, 3'd3);
                    check_eq("awburst", o_awburst, 2'b01);
                    check_eq("awid", o_awid, 4'd0);
                    check_eq("aw_fixed", {o_awlock, o_awcache, o_awprot}, 8'd0);
                end
                if (o_awvalid && i_awready) aw_done = 1'b1;
            end else if (!w_done) begin
                check_eq("wvalid_pass", o_wvalid, wv);
                if (o_wvalid && i_wready) begin
                    check_eq("wd_ready", o_wd_ready, 1'b1);
                    check_eq("wdata", o_wdata, wr_data[wbeat]);
                    check_eq("wstrb", o_wstrb, wr_strb[wbeat]);
                    check_eq("wlast", o_wlast, wbeat == int'(len));
                    check_eq("wid", o_wid, 4'd0);
                    wbeat++;
                    wv = 1'b0;
                    if (wbeat > int'(len)) w_done = 1'b1;
                    if (abort_after != 0 && wbeat == abort_after) aborted = 1'b1;
                end
            end
            if (bv) begin
                check_eq("bready", o_bready, 1'b1);
                if (o_bready) begin
                    b_done = 1'b1;
                    bv = 1'b0;
                end
            end
            if (o_resp_valid) begin
                if (!resp_seen) begin
                    resp_seen = 1'b1;
                    check_eq("wr_err", o_resp_err, exp_err);
                    check_eq("wr_beats", wbeat, int'(len) + 1);
                    if (exp_lat >= 0) check_eq("wr_latency", cyc, exp_lat);
                end
                if (i_resp_ready) done = 1'b1;
            end
        end
        if (aborted) begin
            @(negedge i_aclk);
            i_rst = 1'b1; i_wready = 1'b0; i_wd_valid = 1'b1; i_awready = 1'b0; i_bvalid = 1'b0;
            @(negedge i_aclk);
            i_rst = 1'b0;
            #1;
            check_eq("rst_wvalid", o_wvalid, 1'b0);
            check_eq("rst_req_ready", o_req_ready, 1'b1);
            check_eq("rst_awvalid", o_awvalid, 1'b0);
            check_eq("rst_resp_valid", o_resp_valid, 1'b0);
            i_wd_valid = 1'b0;
        end else begin
            check_eq("wr_done", done, 1'b1);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int len, nb, eb;
        logic [1:0] br;
        logic [3:0] bi;
        idle_inputs();
        i_rst = 1'b1;
        repeat (2) @(posedge i_aclk);
        @(negedge i_aclk);
        i_wd_valid = 1'b1; i_rvalid = 1'b1; i_wready = 1'b1; i_rd_ready = 1'b1;
        #1;
        check_eq("reset_req_ready", o_req_ready, 1'b1);
        check_eq("reset_valids", {o_arvalid, o_awvalid, o_wvalid, o_rd_valid}, 4'd0);
        check_eq("reset_readys", {o_rready, o_bready, o_wd_ready}, 3'd0);
        check_eq("reset_resp", {o_resp_valid, o_resp_err}, 2'd0);
        check_eq("reset_addr_len", {o_araddr, o_arlen}, 40'd0);
        @(negedge i_aclk);
        idle_inputs();
        i_rst = 1'b0;

        slv_rdata = '{64'h1122334455667788};
        do_read(32'h8000_0000, 8'd0, 1, -1, 0, 1'b0, 3);

        slv_rdata = '{64'hA0, 64'hA1, 64'hA2, 64'hA3};
        do_read(32'h8000_0100, 8'd3, 4, -1, 1, 1'b0, -1);

        wr_data = '{64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210};
        wr_strb = '{8'h0F, 8'hF0};
        do_write(32'h8000_0200, 8'd1, 3, 2'b00, 4'd0, 1'b0, 1'b0, -1, 0);

        wr_data = '{64'hDEAD_BEEF};
        wr_strb = '{8'hFF};
        do_write(32'h8000_0300, 8'd0, 0, 2'b10, 4'd0, 1'b0, 1'b0, 4, 0);

        slv_rdata = '{64'hB0, 64'hB1};
        do_read(32'h8000_0400, 8'd3, 2, -1, 0, 1'b0, -1);

        slv_rdata = '{64'hC0, 64'hC1, 64'hC2};
        do_read(32'h8000_0500, 8'd1, 3, -1, 0, 1'b0, -1);

        slv_rdata = '{64'hD0, 64'hD1};
        do_read(32'h8000_0600, 8'd1, 2, 1, 0, 1'b0, -1);

        wr_data = '{64'h1, 64'h2, 64'h3, 64'h4};
        wr_strb = '{8'h01, 8'h02, 8'h04, 8'h08};
        do_write(32'h8000_0700, 8'd3, 0, 2'b00, 4'd0, 1'b0, 1'b0, -1, 1);

        slv_rdata = '{64'h5555_AAAA_5555_AAAA};
        do_read(32'h8000_0800, 8'd0, 1, -1, 0, 1'b0, 3);

        wr_data = '{64'h77};
        wr_strb = '{8'h80};
        do_write(32'h8000_0900, 8'd0, 0, 2'b00, 4'd5, 1'b0, 1'b0, -1, 0);

        for (int t = 0; t < 40; t++) begin
            len = int'($urandom_range(0, 7));
            if ($urandom_range(0, 1) == 1) begin
                wr_data.delete();
                wr_strb.delete();
                for (int i = 0; i <= len; i++) begin
                    wr_data.push_back({$urandom, $urandom});
                    wr_strb.push_back(8'($urandom));
                end
                br = ($urandom_range(0, 7) == 0) ? 2'b10 : 2'b00;
                bi = ($urandom_range(0, 9) == 0) ? 4'd3 : 4'd0;
                do_write({$urandom} & 32'hFFFF_FFF8, 8'(len), int'($urandom_range(0, 3)), br, bi,
                         1'b1, 1'($urandom_range(0, 1)), -1, 0);
            end else begin
                nb = len + 1;
                if ($urandom_range(0, 5) == 0) nb = int'($urandom_range(1, len + 2));
                eb = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, nb - 1)) : -1;
                slv_rdata.delete();
                for (int i = 0; i < nb; i++) slv_rdata.push_back({$urandom, $urandom});
                do_read({$urandom} & 32'hFFFF_FFF8, 8'(len), nb, eb, 2, 1'b1, -1);
            end
        end

        @(negedge i_aclk);
        idle_inputs();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
